// File: rtl/ram_seq_pkg.sv
// Shared encodings for the RAM command sequencer: opcodes, FSM states and
// default geometry of the 16x8 dual-bank RAM.
package ram_seq_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_FILL  = 2'b10,
    OP_DUMP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_ISSUE,
    S_READ_WAIT,
    S_FILL,
    S_DUMP,
    S_DRAIN,
    S_DONE
  } state_e;
endpackage

// File: rtl/ram_seq_rdpipe.sv
// Two-stage delay line: a read issued with address A in cycle t returns
// rd_valid/rd_addr=A in cycle t+2, together with the RAM word captured in t+1.
module ram_seq_rdpipe #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  input  logic [AW-1:0] issue_addr,
  input  logic [DW-1:0] mem_dout,
  output logic          rd_valid,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [1:0]    vld_pipe;
  logic [AW-1:0] addr_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      addr_s1  <= '0;
      rd_addr  <= '0;
      rd_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], issue};
      addr_s1  <= issue_addr;
      rd_addr  <= addr_s1;
      // RAM output is valid in the cycle after the address was presented
      if (vld_pipe[0]) rd_data <= mem_dout;
    end
  end

  assign rd_valid = vld_pipe[1];
endmodule

// File: rtl/ram_seq_ctrl.sv
// Command sequencer in front of the dual-bank RAM: single read/write plus
// whole-bank fill and dump, with registered outputs and a read-return stream.
module ram_seq_ctrl
  import ram_seq_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int FILL_STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic          cmd_bank,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          mem_chos,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          rd_valid,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [DW-1:0] STEP = DW'(FILL_STEP);

  state_e        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] din_n;
  logic          chos_n, we_n, issue, issue_n, busy_n, done_n, ready_n;
  logic          accept;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mem_chos  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      issue     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_chos  <= chos_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_din   <= din_n;
      issue     <= issue_n;
      busy      <= busy_n;
      done      <= done_n;
      cmd_ready <= ready_n;
    end
  end

  // Next-state and next-output values; every output is the registered copy.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    chos_n  = mem_chos;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    din_n   = mem_din;
    issue_n = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
    ready_n = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready_n = 1'b1;
        busy_n  = 1'b0;
        if (accept) begin
          ready_n = 1'b0;
          busy_n  = 1'b1;
          chos_n  = cmd_bank;
          addr_n  = cmd_addr;
          din_n   = cmd_data;
          cnt_n   = '0;
          case (op_e'(cmd_op))
            OP_WRITE: begin state_n = S_WRITE;      we_n    = 1'b1; end
            OP_READ:  begin state_n = S_READ_ISSUE; issue_n = 1'b1; end
            OP_FILL:  begin state_n = S_FILL;       we_n    = 1'b1; end
            default:  begin state_n = S_DUMP;       issue_n = 1'b1; end
          endcase
        end
      end
      S_WRITE: begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
      S_READ_ISSUE: state_n = S_READ_WAIT;
      S_READ_WAIT: begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
      S_FILL: begin
        if (cnt == LAST) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n  = cnt + 1'b1;
          addr_n = mem_addr + 1'b1;
          din_n  = mem_din + STEP;
          we_n   = 1'b1;
        end
      end
      S_DUMP: begin
        if (cnt == LAST) begin
          state_n = S_DRAIN;
        end else begin
          cnt_n   = cnt + 1'b1;
          addr_n  = mem_addr + 1'b1;
          issue_n = 1'b1;
        end
      end
      // last dump word is still in flight through the read pipe
      S_DRAIN: begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
      S_DONE: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  ram_seq_rdpipe #(.AW(AW), .DW(DW)) u_rdpipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .issue_addr (mem_addr),
    .mem_dout   (mem_dout),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );
endmodule

// File: doc/ram_seq_ctrl.md
# ram_seq_ctrl

Command sequencer that sits directly upstream of the 16x8 dual-bank RAM and drives its bank-select, write-enable, address and write-data inputs while capturing its registered read data. It accepts single-word read/write commands plus block fill and block dump commands over a valid/ready handshake, and streams read results with their addresses. The block isolates front-panel or host control logic from the RAM's one-cycle read latency.

## Interface
- DEPTH, 16, number of RAM words per bank; block operations cover exactly DEPTH words.
- AW, 4, address width (log2 DEPTH).
- DW, 8, data width.
- FILL_STEP, 1, data increment per word during fill (mod 2^DW).

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; command accepted on cycle where cmd_valid && cmd_ready.
- cmd_op  in  2  00 WRITE, 01 READ, 10 FILL, 11 DUMP.
- cmd_bank  in  1  bank select value driven onto mem_chos (1 = bank 1, 0 = bank 2).
- cmd_addr  in  AW  target or start address.
- cmd_data  in  DW  write data (WRITE) or start value (FILL); ignored otherwise.
- mem_chos  out  1  to RAM chos.
- mem_we  out  1  to RAM we.
- mem_addr  out  AW  to RAM addr.
- mem_din  out  DW  to RAM din.
- mem_dout  in  DW  from RAM dout (valid one cycle after a we=0 address).
- rd_valid  out  1  one-cycle strobe per returned word.
- rd_addr  out  AW  address of returned word.
- rd_data  out  DW  returned word.
- busy  out  1  high from cycle after accept through done cycle.
- done  out  1  one-cycle pulse at command completion.

## Operation
- All outputs registered. Reset value of every output 0 except cmd_ready = 1 after reset release (state IDLE).
- States: IDLE, WRITE, READ_ISSUE, READ_WAIT, FILL, DUMP, DRAIN, DONE.
- Command fields latched on acceptance; cmd_* ignored while not IDLE.
- WRITE: one cycle mem_we=1, mem_addr=cmd_addr, mem_din=cmd_data -> DONE -> IDLE.
- READ: READ_ISSUE (mem_we=0, mem_addr=cmd_addr) -> READ_WAIT (mem_dout valid, captured) -> DONE with rd_valid=1, rd_addr=cmd_addr.
- FILL: DEPTH consecutive write cycles; word i at address (cmd_addr+i) mod DEPTH, data (cmd_data + i*FILL_STEP) mod 2^DW; -> DONE.
- DUMP: DEPTH consecutive read-issue cycles at (cmd_addr+i) mod DEPTH; capture pipeline delays address/valid by 2 cycles; DRAIN waits for the last word; done coincides with the last rd_valid.
- mem_chos = latched cmd_bank for the whole command, held at that value in IDLE; mem_we=0 outside WRITE/FILL.
- Address counter wraps DEPTH-1 -> 0 silently; data adder wraps mod 2^DW.
- rst_n low at any time: immediate return to IDLE, mem_we forced 0, no done, no further rd_valid; partially written RAM contents are not restored.

## Timing
- Accept at cycle 0.
- WRITE: mem_we high cycle 1; done cycle 2; cmd_ready cycle 3.
- READ: address cycle 1; RAM data cycle 2; rd_valid+done cycle 3; cmd_ready cycle 4.
- FILL: mem_we cycles 1..DEPTH; done cycle DEPTH+1; cmd_ready DEPTH+2.
- DUMP: addresses cycles 1..DEPTH; rd_valid cycles 3..DEPTH+2, contiguous; done cycle DEPTH+2; cmd_ready DEPTH+3.
- No back-to-back acceptance: at least one IDLE cycle between commands.

## Structure
- Package ram_seq_pkg: op encodings (OP_WRITE, OP_READ, OP_FILL, OP_DUMP), state enum, default DEPTH/AW/DW.
- Sub-module ram_seq_rdpipe: 2-stage valid/address delay line aligning rd_addr with captured mem_dout; shared by READ and DUMP.
- Bench instantiates the RAM model with both banks behind this block.

## Test plan
- Reset mid-FILL (rst_n low at cycle 5): mem_we 0 immediately, all outputs 0, cmd_ready 1 after release, no done.
- WRITE bank1 addr 3 data 0xA5, then READ bank1 addr 3 -> rd_valid cycle 3 with rd_addr 3, rd_data 0xA5; bank2 addr 3 unchanged.
- FILL bank0 start addr 14 data 0xFE, FILL_STEP 1 -> addr 14=0xFE, 15=0xFF, 0=0x00 ... 13=0x0D; done at cycle 17.
- DUMP after that fill from addr 14 -> 16 contiguous rd_valid cycles 3..18, rd_addr 14,15,0..13, data matching fill; done with last strobe.
- cmd_valid held high with changing cmd_op during DUMP -> no acceptance until cmd_ready, stream unaffected.
